// File: rtl/cnn_settle_monitor_if.sv
// Handshake and data bundle for cnn_settle_monitor: control pulses, 4x4 cell states, result fields.
`timescale 1ns/1ps
interface cnn_settle_monitor_if #(
   parameter int unsigned WIDTH = 9
);
   logic                      start;
   logic                      frame_tick;
   logic                      result_ready;
   logic signed [2*WIDTH-1:0] Y1_in,  Y2_in,  Y3_in,  Y4_in;
   logic signed [2*WIDTH-1:0] Y5_in,  Y6_in,  Y7_in,  Y8_in;
   logic signed [2*WIDTH-1:0] Y9_in,  Y10_in, Y11_in, Y12_in;
   logic signed [2*WIDTH-1:0] Y13_in, Y14_in, Y15_in, Y16_in;
   logic                      busy;
   logic                      result_valid;
   logic                      converged;
   logic                      timed_out;
   logic [15:0]               pixels;
   logic [7:0]                iter_count;
   logic                      overrun;

   modport master (
      output start, frame_tick, result_ready,
      output Y1_in, Y2_in, Y3_in, Y4_in, Y5_in, Y6_in, Y7_in, Y8_in,
      output Y9_in, Y10_in, Y11_in, Y12_in, Y13_in, Y14_in, Y15_in, Y16_in,
      input  busy, result_valid, converged, timed_out, pixels, iter_count, overrun
   );

   modport slave (
      input  start, frame_tick, result_ready,
      input  Y1_in, Y2_in, Y3_in, Y4_in, Y5_in, Y6_in, Y7_in, Y8_in,
      input  Y9_in, Y10_in, Y11_in, Y12_in, Y13_in, Y14_in, Y15_in, Y16_in,
      output busy, result_valid, converged, timed_out, pixels, iter_count, overrun
   );
endinterface

// File: rtl/cnn_settle_monitor.sv
// Watches a 4x4 CNN state array frame by frame and reports when the saturated outputs settle
// (or when the frame budget runs out). One cell is compared per cycle after each captured frame.
`timescale 1ns/1ps
module cnn_settle_monitor #(
   parameter int unsigned WIDTH    = 9,
   parameter int unsigned ONE      = 64,
   parameter int unsigned TOL      = 2,
   parameter int unsigned STABLE_N = 3,
   parameter int unsigned MAX_ITER = 255
) (
   input logic              clk,
   input logic              rst,
   cnn_settle_monitor_if.slave bus
);

   localparam int unsigned SW    = 2 * WIDTH;
   localparam int unsigned NCELL = 16;

   localparam logic signed [SW-1:0] SAT_POS = SW'(ONE);
   localparam logic signed [SW-1:0] SAT_NEG = -SAT_POS;
   localparam logic signed [SW:0]   TOL_POS = (SW + 1)'(TOL);
   localparam logic signed [SW:0]   TOL_NEG = -TOL_POS;

   typedef enum logic [1:0] {StIdle, StArmed, StScan, StDone} state_e;

   state_e               state_q, state_d;
   logic signed [SW-1:0] frame_q [NCELL];
   logic signed [SW-1:0] frame_d [NCELL];
   logic signed [SW-1:0] prev_q  [NCELL];
   logic signed [SW-1:0] prev_d  [NCELL];
   logic [15:0]          pixels_q, pixels_d;
   logic [7:0]           iter_q, iter_d;
   logic [3:0]           stable_q, stable_d;
   logic [3:0]           idx_q, idx_d;
   logic                 unch_q, unch_d;
   logic                 prev_valid_q, prev_valid_d;
   logic                 converged_q, converged_d;
   logic                 timed_out_q, timed_out_d;
   logic                 overrun_q, overrun_d;

   logic signed [SW-1:0] y_in [NCELL];
   logic signed [SW-1:0] cur_y, cur_prev, sat;
   logic signed [SW:0]   diff;
   logic                 changed;
   logic                 frame_unch;
   logic [3:0]           stable_inc;

   assign y_in[0]  = bus.Y1_in;
   assign y_in[1]  = bus.Y2_in;
   assign y_in[2]  = bus.Y3_in;
   assign y_in[3]  = bus.Y4_in;
   assign y_in[4]  = bus.Y5_in;
   assign y_in[5]  = bus.Y6_in;
   assign y_in[6]  = bus.Y7_in;
   assign y_in[7]  = bus.Y8_in;
   assign y_in[8]  = bus.Y9_in;
   assign y_in[9]  = bus.Y10_in;
   assign y_in[10] = bus.Y11_in;
   assign y_in[11] = bus.Y12_in;
   assign y_in[12] = bus.Y13_in;
   assign y_in[13] = bus.Y14_in;
   assign y_in[14] = bus.Y15_in;
   assign y_in[15] = bus.Y16_in;

   // Per-cell compare datapath for the cell currently selected by idx_q.
   always_comb begin
      cur_y    = frame_q[idx_q];
      cur_prev = prev_q[idx_q];
      if (cur_y > SAT_POS) begin
         sat = SAT_POS;
      end else if (cur_y < SAT_NEG) begin
         sat = SAT_NEG;
      end else begin
         sat = cur_y;
      end
      diff       = {sat[SW-1], sat} - {cur_prev[SW-1], cur_prev};
      changed    = (diff > TOL_POS) || (diff < TOL_NEG);
      frame_unch = unch_q && !changed && prev_valid_q;
      stable_inc = frame_unch ? stable_q + 4'd1 : 4'd0;
   end

   always_comb begin
      state_d      = state_q;
      frame_d      = frame_q;
      prev_d       = prev_q;
      pixels_d     = pixels_q;
      iter_d       = iter_q;
      stable_d     = stable_q;
      idx_d        = idx_q;
      unch_d       = unch_q;
      prev_valid_d = prev_valid_q;
      converged_d  = converged_q;
      timed_out_d  = timed_out_q;
      overrun_d    = overrun_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d      = StArmed;
               stable_d     = 4'd0;
               iter_d       = 8'd0;
               overrun_d    = 1'b0;
               prev_valid_d = 1'b0;
               converged_d  = 1'b0;
               timed_out_d  = 1'b0;
            end
         end
         StArmed: begin
            if (bus.frame_tick) begin
               for (int i = 0; i < int'(NCELL); i++) begin
                  frame_d[i] = y_in[i];
               end
               iter_d  = (iter_q == 8'hFF) ? iter_q : iter_q + 8'd1;
               unch_d  = 1'b1;
               idx_d   = 4'd0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (bus.frame_tick) begin
               overrun_d = 1'b1;
            end
            prev_d[idx_q]   = sat;
            pixels_d[idx_q] = ~sat[SW-1];
            unch_d          = unch_q && !changed;
            idx_d           = idx_q + 4'd1;
            if (idx_q == 4'(NCELL - 1)) begin
               prev_valid_d = 1'b1;
               stable_d     = stable_inc;
               // Convergence wins over timeout when both land on the same frame.
               if (stable_inc == 4'(STABLE_N)) begin
                  converged_d = 1'b1;
                  state_d     = StDone;
               end else if (iter_q == 8'(MAX_ITER)) begin
                  timed_out_d = 1'b1;
                  state_d     = StDone;
               end else begin
                  state_d = StArmed;
               end
            end
         end
         StDone: begin
            if (bus.result_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         for (int i = 0; i < int'(NCELL); i++) begin
            frame_q[i] <= '0;
            prev_q[i]  <= '0;
         end
         pixels_q     <= 16'h0000;
         iter_q       <= 8'd0;
         stable_q     <= 4'd0;
         idx_q        <= 4'd0;
         unch_q       <= 1'b0;
         prev_valid_q <= 1'b0;
         converged_q  <= 1'b0;
         timed_out_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_q      <= frame_d;
         prev_q       <= prev_d;
         pixels_q     <= pixels_d;
         iter_q       <= iter_d;
         stable_q     <= stable_d;
         idx_q        <= idx_d;
         unch_q       <= unch_d;
         prev_valid_q <= prev_valid_d;
         converged_q  <= converged_d;
         timed_out_q  <= timed_out_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.busy         = (state_q == StArmed) || (state_q == StScan);
   assign bus.result_valid = (state_q == StDone);
   assign bus.converged    = converged_q;
   assign bus.timed_out    = timed_out_q;
   assign bus.pixels       = pixels_q;
   assign bus.iter_count   = iter_q;
   assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_cnn_settle_monitor.sv
// Scoreboard bench: a frame-level settle model predicts each run's result, compared when it appears.
`timescale 1ns/1ps
module tb_cnn_settle_monitor;

   localparam int W      = 9;
   localparam int ONE_V  = 64;
   localparam int TOL_V  = 2;
   localparam int STAB_V = 3;

   typedef struct {
      bit          done;
      bit          conv;
      bit          tout;
      logic [15:0] pix;
      logic [7:0]  iter;
   } res_t;

   logic clk = 1'b0;
   logic rst, start, frame_tick, result_ready;
   logic signed [2*W-1:0] yv [16];

   int   checks = 0;
   int   failures = 0;
   res_t exp_q[$];
   res_t exp5_q[$];

   always #5 clk = ~clk;

   cnn_settle_monitor_if #(.WIDTH(W)) bus ();
   cnn_settle_monitor_if #(.WIDTH(W)) bus5 ();

   assign bus.start = start;               assign bus5.start = start;
   assign bus.frame_tick = frame_tick;     assign bus5.frame_tick = frame_tick;
   assign bus.result_ready = result_ready; assign bus5.result_ready = result_ready;
   assign bus.Y1_in  = yv[0];  assign bus5.Y1_in  = yv[0];
   assign bus.Y2_in  = yv[1];  assign bus5.Y2_in  = yv[1];
   assign bus.Y3_in  = yv[2];  assign bus5.Y3_in  = yv[2];
   assign bus.Y4_in  = yv[3];  assign bus5.Y4_in  = yv[3];
   assign bus.Y5_in  = yv[4];  assign bus5.Y5_in  = yv[4];
   assign bus.Y6_in  = yv[5];  assign bus5.Y6_in  = yv[5];
   assign bus.Y7_in  = yv[6];  assign bus5.Y7_in  = yv[6];
   assign bus.Y8_in  = yv[7];  assign bus5.Y8_in  = yv[7];
   assign bus.Y9_in  = yv[8];  assign bus5.Y9_in  = yv[8];
   assign bus.Y10_in = yv[9];  assign bus5.Y10_in = yv[9];
   assign bus.Y11_in = yv[10]; assign bus5.Y11_in = yv[10];
   assign bus.Y12_in = yv[11]; assign bus5.Y12_in = yv[11];
   assign bus.Y13_in = yv[12]; assign bus5.Y13_in = yv[12];
   assign bus.Y14_in = yv[13]; assign bus5.Y14_in = yv[13];
   assign bus.Y15_in = yv[14]; assign bus5.Y15_in = yv[14];
   assign bus.Y16_in = yv[15]; assign bus5.Y16_in = yv[15];

   cnn_settle_monitor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   cnn_settle_monitor #(.WIDTH(W), .MAX_ITER(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

   function automatic int clampv(input int v);
      if (v > ONE_V) return ONE_V;
      if (v < -ONE_V) return -ONE_V;
      return v;
   endfunction

   // Frame-level model: uniform frames alternating a, b; run ends at frame n or earlier.
   function automatic res_t model(input int a, input int b, input int n, input int maxit);
      res_t r;
      int   prev = 0;
      int   stable = 0;
      int   s, d;
      r = '{done: 0, conv: 0, tout: 0, pix: 16'h0, iter: 8'h0};
      for (int i = 0; i < n; i++) begin
         s = clampv((i % 2 == 1) ? b : a);
         d = s - prev;
         if (d < 0) d = -d;
         stable = (i > 0 && d <= TOL_V) ? stable + 1 : 0;
         prev = s;
         r.pix = (s >= 0) ? 16'hFFFF : 16'h0000;
         r.iter = 8'(i + 1);
         if (stable == STAB_V) begin
            r.conv = 1; r.done = 1; return r;
         end else if (i + 1 == maxit) begin
            r.tout = 1; r.done = 1; return r;
         end
      end
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1; start = 0; frame_tick = 0; result_ready = 0;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
   endtask

   task automatic pulse_frame(input int v);
      @(negedge clk);
      for (int i = 0; i < 16; i++) yv[i] = 18'(v);
      frame_tick = 1;
      @(negedge clk);
      frame_tick = 0;
   endtask

   // Ticks 20 cycles apart; returns one negedge after the last tick.
   task automatic play(input int a, input int b, input int n);
      for (int i = 0; i < n; i++) begin
         pulse_frame((i % 2 == 1) ? b : a);
         if (i < n - 1) repeat (18) @(negedge clk);
      end
   endtask

   // Latency counted in cycles from the tick cycle.
   task automatic wait_valid(input bit sel, output int lat);
      lat = 1;
      while (((sel ? bus5.result_valid : bus.result_valid) !== 1'b1) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1; start = 0; frame_tick = 0; result_ready = 0;
      for (int i = 0; i < 16; i++) yv[i] = '0;
      repeat (2) @(negedge clk);
      rst = 0;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", bus.result_valid); end
      checks++; if (bus.converged !== 1'b0) begin failures++; $display("FAIL rst_conv got=%0b exp=0", bus.converged); end
      checks++; if (bus.timed_out !== 1'b0) begin failures++; $display("FAIL rst_tout got=%0b exp=0", bus.timed_out); end
      checks++; if (bus.pixels !== 16'h0) begin failures++; $display("FAIL rst_pixels got=%0h exp=0", bus.pixels); end
      checks++; if (bus.iter_count !== 8'h0) begin failures++; $display("FAIL rst_iter got=%0d exp=0", bus.iter_count); end
      checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%0b exp=0", bus.overrun); end
      pulse_start();
      repeat (100) @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL armed_busy got=%0b exp=1", bus.busy); end
      checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL armed_valid got=%0b exp=0", bus.result_valid); end
   endtask

   task automatic test_converge();
      res_t e;
      int   lat;
      logic [15:0] pix0;
      logic [7:0]  it0;
      do_reset();
      pulse_start();
      exp_q.push_back(model(100, 100, 4, 255));
      play(100, 100, 4);
      wait_valid(0, lat);
      e = exp_q.pop_front();
      checks++; if (lat !== 17) begin failures++; $display("FAIL conv_latency got=%0d exp=17", lat); end
      checks++; if (bus.converged !== e.conv) begin failures++; $display("FAIL conv_flag got=%0b exp=%0b", bus.converged, e.conv); end
      checks++; if (bus.timed_out !== e.tout) begin failures++; $display("FAIL conv_tout got=%0b exp=%0b", bus.timed_out, e.tout); end
      checks++; if (bus.pixels !== e.pix) begin failures++; $display("FAIL conv_pixels got=%0h exp=%0h", bus.pixels, e.pix); end
      checks++; if (bus.iter_count !== e.iter) begin failures++; $display("FAIL conv_iter got=%0d exp=%0d", bus.iter_count, e.iter); end
      pix0 = e.pix; it0 = e.iter;
      // Stray start and frame_tick in DONE must not disturb anything.
      start = 1; frame_tick = 1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         start = 0; frame_tick = 0;
         checks++;
         if (bus.result_valid !== 1'b1 || bus.pixels !== pix0 || bus.iter_count !== it0 ||
             bus.converged !== 1'b1) begin
            failures++;
            $display("FAIL done_hold cyc=%0d valid=%0b pix=%0h iter=%0d conv=%0b", c,
                     bus.result_valid, bus.pixels, bus.iter_count, bus.converged);
         end
      end
      result_ready = 1;
      @(negedge clk);
      result_ready = 0;
      checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL ack_valid got=%0b exp=0", bus.result_valid); end
      checks++; if (bus.pixels !== pix0 || bus.iter_count !== it0 || bus.converged !== 1'b1) begin
         failures++; $display("FAIL ack_retain pix=%0h iter=%0d conv=%0b", bus.pixels, bus.iter_count, bus.converged);
      end
   endtask

   task automatic test_timeout();
      res_t e;
      int   lat;
      do_reset();
      pulse_start();
      exp5_q.push_back(model(-10, 10, 5, 5));
      play(-10, 10, 5);
      wait_valid(1, lat);
      e = exp5_q.pop_front();
      checks++; if (lat !== 17) begin failures++; $display("FAIL tout_latency got=%0d exp=17", lat); end
      checks++; if (bus5.timed_out !== e.tout) begin failures++; $display("FAIL tout_flag got=%0b exp=%0b", bus5.timed_out, e.tout); end
      checks++; if (bus5.converged !== e.conv) begin failures++; $display("FAIL tout_conv got=%0b exp=%0b", bus5.converged, e.conv); end
      checks++; if (bus5.pixels !== e.pix) begin failures++; $display("FAIL tout_pixels got=%0h exp=%0h", bus5.pixels, e.pix); end
      checks++; if (bus5.iter_count !== e.iter) begin failures++; $display("FAIL tout_iter got=%0d exp=%0d", bus5.iter_count, e.iter); end
   endtask

   task automatic test_tol_boundary();
      res_t e;
      int   lat;
      do_reset();
      pulse_start();
      exp_q.push_back(model(20, 22, 4, 255));
      play(20, 22, 4);
      wait_valid(0, lat);
      e = exp_q.pop_front();
      checks++; if (bus.converged !== e.conv || bus.iter_count !== e.iter) begin
         failures++; $display("FAIL tol_in conv=%0b iter=%0d exp conv=%0b iter=%0d", bus.converged, bus.iter_count, e.conv, e.iter);
      end
      do_reset();
      pulse_start();
      exp5_q.push_back(model(20, 23, 5, 5));
      play(20, 23, 5);
      wait_valid(1, lat);
      e = exp5_q.pop_front();
      checks++; if (bus5.converged !== e.conv || bus5.timed_out !== e.tout || bus5.iter_count !== e.iter) begin
         failures++; $display("FAIL tol_out conv=%0b tout=%0b iter=%0d exp %0b %0b %0d", bus5.converged,
                              bus5.timed_out, bus5.iter_count, e.conv, e.tout, e.iter);
      end
      checks++; if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
         failures++; $display("FAIL tol_out_default busy=%0b valid=%0b exp busy=1 valid=0", bus.busy, bus.result_valid);
      end
   endtask

   task automatic test_pixels();
      int   lat;
      int   va [4];
      int   vb [4];
      logic [15:0] epix;
      res_t e;
      va = '{500, -3, 0, -500};
      vb = '{70, -5, 1, -66};
      epix = '0;
      for (int i = 0; i < 16; i++) epix[i] = (clampv(vb[i % 4]) >= 0);
      e = '{done: 1, conv: 1, tout: 0, pix: epix, iter: 8'd4};
      exp_q.push_back(e);
      do_reset();
      pulse_start();
      for (int f = 0; f < 4; f++) begin
         @(negedge clk);
         for (int i = 0; i < 16; i++) yv[i] = 18'((f % 2 == 1) ? vb[i % 4] : va[i % 4]);
         frame_tick = 1;
         @(negedge clk);
         frame_tick = 0;
         if (f < 3) repeat (18) @(negedge clk);
      end
      wait_valid(0, lat);
      e = exp_q.pop_front();
      checks++; if (bus.pixels !== e.pix) begin failures++; $display("FAIL pix_pattern got=%0h exp=%0h", bus.pixels, e.pix); end
      checks++; if (bus.converged !== e.conv || bus.iter_count !== e.iter) begin
         failures++; $display("FAIL pix_conv conv=%0b iter=%0d exp conv=1 iter=4", bus.converged, bus.iter_count);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      pulse_start();
      pulse_frame(100);
      repeat (3) @(negedge clk);
      checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%0b exp=0", bus.overrun); end
      @(negedge clk); frame_tick = 1;
      @(negedge clk); frame_tick = 0;
      checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%0b exp=1", bus.overrun); end
      checks++; if (bus.iter_count !== 8'd1) begin failures++; $display("FAIL overrun_iter got=%0d exp=1", bus.iter_count); end
      repeat (14) @(negedge clk);
      pulse_frame(100);
      checks++; if (bus.iter_count !== 8'd2 || bus.overrun !== 1'b1) begin
         failures++; $display("FAIL overrun_next iter=%0d ovr=%0b exp iter=2 ovr=1", bus.iter_count, bus.overrun);
      end
   endtask

   task automatic test_reset_mid_scan();
      res_t e;
      int   lat;
      do_reset();
      pulse_start();
      pulse_frame(100);
      repeat (6) @(negedge clk);
      checks++; if (bus.busy !== 1'b1 || bus.pixels === 16'h0) begin
         failures++; $display("FAIL midscan_pre busy=%0b pix=%0h exp busy=1 pix!=0", bus.busy, bus.pixels);
      end
      rst = 1; start = 1; frame_tick = 1; result_ready = 1;
      @(negedge clk);
      rst = 0; start = 0; frame_tick = 0; result_ready = 0;
      checks++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.converged !== 1'b0 ||
                    bus.timed_out !== 1'b0 || bus.overrun !== 1'b0 || bus.pixels !== 16'h0 ||
                    bus.iter_count !== 8'h0) begin
         failures++; $display("FAIL midscan_rst busy=%0b valid=%0b pix=%0h iter=%0d ovr=%0b exp all 0",
                              bus.busy, bus.result_valid, bus.pixels, bus.iter_count, bus.overrun);
      end
      pulse_start();
      exp_q.push_back(model(100, 100, 4, 255));
      play(100, 100, 4);
      wait_valid(0, lat);
      e = exp_q.pop_front();
      checks++; if (lat !== 17 || bus.converged !== e.conv || bus.pixels !== e.pix || bus.iter_count !== e.iter) begin
         failures++; $display("FAIL midscan_rerun lat=%0d conv=%0b pix=%0h iter=%0d exp 17 %0b %0h %0d", lat,
                              bus.converged, bus.pixels, bus.iter_count, e.conv, e.pix, e.iter);
      end
   endtask

   initial begin
      test_reset();
      test_converge();
      test_timeout();
      test_tol_boundary();
      test_pixels();
      test_overrun();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
